vga_sync_gen: RTL and testbench

- Consumes the pixel-rate enable that the clock divider derives (100 MHz / 4 = 25 MHz) and generates 640x480@60 VGA timing.
- Outputs: hsync, vsync, active-video flag, pixel coordinates, and line/frame strobes.
- Runs on the system clock, advancing only on enabled cycles.
- Feeds the pixel renderer (bird/pipe drawing) and the game logic that steps once per frame.

---
 rtl/vga_sync_gen.sv | 126 ++++++++++++
 tb/tb_vga_sync_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters advanced by a pixel-rate enable,
// with one registered output stage carrying sync, blanking, coordinates and wrap strobes.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0,
  parameter int unsigned CW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_tick,
  output logic          frame_tick,
  output logic [15:0]   frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CW1     = CW + 1;

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // Bounds are one bit wider so a bound equal to 2^CW still compares correctly.
  localparam logic [CW:0] H_ACT_L = CW1'(H_ACTIVE);
  localparam logic [CW:0] V_ACT_L = CW1'(V_ACTIVE);
  localparam logic [CW:0] HS_BEG  = CW1'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_LIM  = CW1'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] VS_BEG  = CW1'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_LIM  = CW1'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_cnt_r;
  logic [CW-1:0] v_cnt_r;
  logic          h_wrap_r;
  logic          f_wrap_r;

  logic          h_end_s;
  logic          v_end_s;
  logic          h_wrap_s;
  logic          f_wrap_s;
  logic          h_vis_s;
  logic          v_vis_s;
  logic          hs_in_s;
  logic          vs_in_s;

  // End-of-line / end-of-frame detection and raster region decode.
  always_comb begin
    h_end_s  = (h_cnt_r == H_LAST);
    v_end_s  = (v_cnt_r == V_LAST);
    h_wrap_s = pix_en && h_end_s;
    f_wrap_s = h_wrap_s && v_end_s;
    h_vis_s  = ({1'b0, h_cnt_r} < H_ACT_L);
    v_vis_s  = ({1'b0, v_cnt_r} < V_ACT_L);
    hs_in_s  = ({1'b0, h_cnt_r} >= HS_BEG) && ({1'b0, h_cnt_r} < HS_LIM);
    vs_in_s  = ({1'b0, v_cnt_r} >= VS_BEG) && ({1'b0, v_cnt_r} < VS_LIM);
  end

  // Raster position counters; the wrap flags remember that a wrap just happened
  // so the output stage can emit exactly one strobe per wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r  <= '0;
      v_cnt_r  <= '0;
      h_wrap_r <= 1'b0;
      f_wrap_r <= 1'b0;
    end else begin
      h_wrap_r <= h_wrap_s;
      f_wrap_r <= f_wrap_s;
      if (pix_en) begin
        if (h_end_s) begin
          h_cnt_r <= '0;
          if (v_end_s) begin
            v_cnt_r <= '0;
          end else begin
            v_cnt_r <= v_cnt_r + CNT_ONE;
          end
        end else begin
          h_cnt_r <= h_cnt_r + CNT_ONE;
        end
      end else begin
        h_cnt_r <= h_cnt_r;
        v_cnt_r <= v_cnt_r;
      end
    end
  end

  // Registered outputs: all lag the counters by one clk and stay mutually aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x          <= '0;
      y          <= '0;
      video_on   <= 1'b0;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= 16'h0000;
    end else begin
      x          <= h_cnt_r;
      y          <= v_cnt_r;
      video_on   <= h_vis_s && v_vis_s;
      hsync      <= hs_in_s ? SYNC_POL : ~SYNC_POL;
      vsync      <= vs_in_s ? SYNC_POL : ~SYNC_POL;
      line_tick  <= h_wrap_r;
      frame_tick <= f_wrap_r;
      if (f_wrap_r) begin
        frame_cnt <= frame_cnt + 16'h0001;
      end else begin
        frame_cnt <= frame_cnt;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: three generator instances checked every clk against a model that
// derives raster position, syncs, strobes and frame count from the number of enabled pixels.
module tb_vga_sync_gen;

  logic clk;
  logic rst_n0, rst_n1;
  logic pix_en0, pix_en1, pix_en2;

  logic       hs0, vs0, vo0, lt0, ft0;
  logic [9:0] x0, y0;
  logic [15:0] fc0;
  logic       hs1, vs1, vo1, lt1, ft1;
  logic [9:0] x1, y1;
  logic [15:0] fc1;
  logic       hs2, vs2, vo2, lt2, ft2;
  logic [9:0] x2, y2;
  logic [15:0] fc2;

  int n_cmp = 0;
  int n_err = 0;

  longint cnt0, cnt1, cnt2;
  bit le0, le1, le2;
  bit rs0, rs1;

  assign pix_en2 = 1'b1;

  vga_sync_gen u0 (
    .clk(clk), .rst_n(rst_n0), .pix_en(pix_en0),
    .hsync(hs0), .vsync(vs0), .video_on(vo0), .x(x0), .y(y0),
    .line_tick(lt0), .frame_tick(ft0), .frame_cnt(fc0)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .CW(10)
  ) u1 (
    .clk(clk), .rst_n(rst_n1), .pix_en(pix_en1),
    .hsync(hs1), .vsync(vs1), .video_on(vo1), .x(x1), .y(y1),
    .line_tick(lt1), .frame_tick(ft1), .frame_cnt(fc1)
  );

  // One-pixel frame: every enabled clk is a frame wrap, so frame_cnt wraps quickly.
  vga_sync_gen #(
    .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
    .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0),
    .SYNC_POL(1'b0), .CW(10)
  ) u2 (
    .clk(clk), .rst_n(rst_n1), .pix_en(pix_en2),
    .hsync(hs2), .vsync(vs2), .video_on(vo2), .x(x2), .y(y2),
    .line_tick(lt2), .frame_tick(ft2), .frame_cnt(fc2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      if (n_err <= 20) $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for a count c of enabled pixels since reset; le is whether the
  // previous clk had pix_en, rs whether reset is asserted now.
  task automatic chk_dut(input string nm, input longint c, input bit le, input bit rs,
                         input int ha, input int hf, input int hsw, input int hb,
                         input int va, input int vf, input int vsw, input int vb,
                         input bit pol,
                         input logic [9:0] ox, input logic [9:0] oy,
                         input logic ohs, input logic ovs, input logic ovo,
                         input logic olt, input logic oft, input logic [15:0] ofc);
    longint ht, vt, h, v, f;
    bit e_vo, e_hs, e_vs, e_lt, e_ft;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (rs) begin
      h = 0; v = 0; f = 0;
      e_vo = 1'b0; e_hs = ~pol; e_vs = ~pol; e_lt = 1'b0; e_ft = 1'b0;
    end else begin
      h = c % ht;
      v = (c / ht) % vt;
      f = (c / (ht * vt)) % 65536;
      e_vo = (h < ha) && (v < va);
      e_hs = (h >= ha + hf && h < ha + hf + hsw) ? pol : ~pol;
      e_vs = (v >= va + vf && v < va + vf + vsw) ? pol : ~pol;
      e_lt = le && (h == 0);
      e_ft = le && (h == 0) && (v == 0);
    end
    chk({nm, "_x"},  32'(ox),  32'(h));
    chk({nm, "_y"},  32'(oy),  32'(v));
    chk({nm, "_vo"}, 32'(ovo), 32'(e_vo));
    chk({nm, "_hs"}, 32'(ohs), 32'(e_hs));
    chk({nm, "_vs"}, 32'(ovs), 32'(e_vs));
    chk({nm, "_lt"}, 32'(olt), 32'(e_lt));
    chk({nm, "_ft"}, 32'(oft), 32'(e_ft));
    chk({nm, "_fc"}, 32'(ofc), 32'(f));
  endtask

  task automatic step(input bit e0, input bit e1);
    pix_en0 = e0;
    pix_en1 = e1;
    @(posedge clk);
    #1;
    chk_dut("u0", cnt0, le0, rs0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
            x0, y0, hs0, vs0, vo0, lt0, ft0, fc0);
    chk_dut("u1", cnt1, le1, rs1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1,
            x1, y1, hs1, vs1, vo1, lt1, ft1, fc1);
    chk_dut("u2", cnt2, le2, rs1, 1, 0, 0, 0, 1, 0, 0, 0, 1'b0,
            x2, y2, hs2, vs2, vo2, lt2, ft2, fc2);
    if (!rs0) begin
      cnt0 += longint'(e0);
      le0 = e0;
    end
    if (!rs1) begin
      cnt1 += longint'(e1);
      le1 = e1;
      cnt2 += 1;
      le2 = 1'b1;
    end
  endtask

  initial begin
    int g0, g1;
    bit e0, e1;
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    pix_en0 = 1'b0; pix_en1 = 1'b0;
    cnt0 = 0; cnt1 = 0; cnt2 = 0;
    le0 = 1'b0; le1 = 1'b0; le2 = 1'b0;
    rs0 = 1'b1; rs1 = 1'b1;

    // Reset state, with pix_en toggling to show it is ignored under reset.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    #4;
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    rs0 = 1'b0; rs1 = 1'b0;

    // One full default line at pix_en every 4th clk, plus the wrap back to x=0.
    for (int i = 0; i < 3208; i++) begin
      step(i % 4 == 3, 1'($urandom_range(0, 1)));
    end

    // Random gaps of 0..50 clks between enabled pixels.
    g0 = 0; g1 = 0;
    for (int i = 0; i < 10000; i++) begin
      if (g0 == 0) begin e0 = 1'b1; g0 = int'($urandom_range(0, 50)); end
      else begin e0 = 1'b0; g0--; end
      if (g1 == 0) begin e1 = 1'b1; g1 = int'($urandom_range(0, 50)); end
      else begin e1 = 1'b0; g1--; end
      step(e0, e1);
    end

    // Advance u0 to x=300, then assert reset between clock edges.
    for (int i = 0; i < 2000 && (cnt0 % 800) != 300; i++) begin
      step(1'b1, 1'b1);
    end
    chk("reach_x300", 32'(cnt0 % 800), 32'd300);
    step(1'b0, 1'b1);
    #2;
    rst_n0 = 1'b0;
    #1;
    chk_dut("u0_async", 0, 1'b0, 1'b1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
            x0, y0, hs0, vs0, vo0, lt0, ft0, fc0);
    cnt0 = 0; le0 = 1'b0; rs0 = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    #4;
    rst_n0 = 1'b1;
    rs0 = 1'b0;

    // Continuous pix_en on u0/u1 until the one-pixel instance wraps frame_cnt past 0xFFFF.
    for (int i = 0; i < 70000 && cnt2 < 65540; i++) begin
      step(1'b1, (i < 400) ? 1'b1 : 1'($urandom_range(0, 3) == 0));
    end
    chk("u2_wrapped", 32'(cnt2 >= 65537), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
